// File: rtl/spi_frame_pkg.sv
// Shared constants, FSM state type and frame-length helper for the SPI frame slave.
package spi_frame_pkg;

   // Trailer byte offsets, relative to byte 4*CH
   localparam int TRL_DOUT_LO  = 0;
   localparam int TRL_DOUT_HI  = 1;
   localparam int TRL_DIRTIME  = 2;
   localparam int TRL_STEPTIME = 3;
   localparam int TRL_DIN_LO   = 0;
   localparam int TRL_DIN_HI   = 1;
   localparam int TRL_STATUS   = 2;
   localparam int TRL_SEQ      = 3;

   localparam int STAT_LEN_LSB = 4;
   localparam int STAT_CRC_LSB = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   function automatic int frame_len(input int ch, input bit crc_en);
      return 4 * ch + 4 + (crc_en ? 1 : 0);
   endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Pin synchronisers, edge detect and the mode-0 byte shift engine for the SPI frame slave.
module spi_byte_shifter #(
   parameter int SYNC = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sck,
   input  logic       ssel,
   input  logic       mosi,
   input  logic       tx_load,
   input  logic [7:0] tx_byte,
   output logic       miso,
   output logic       start,
   output logic       stop,
   output logic       byte_done,
   output logic [7:0] rx_byte,
   output logic [2:0] bit_cnt
);

   logic [SYNC-1:0] sck_sync, ssel_sync, mosi_sync;
   logic            sck_prev, ssel_prev;
   logic            sck_s, ssel_s, mosi_s, sck_rise, sck_fall;
   logic [7:0]      rx_sr, tx_sr;

   assign sck_s    = sck_sync[SYNC-1];
   assign ssel_s   = ssel_sync[SYNC-1];
   assign mosi_s   = mosi_sync[SYNC-1];
   assign sck_rise = sck_s & ~sck_prev;
   assign sck_fall = ~sck_s & sck_prev;
   assign miso     = tx_sr[7];

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_sync  <= '0;
         ssel_sync <= '0;
         mosi_sync <= '0;
         sck_prev  <= 1'b0;
         ssel_prev <= 1'b0;
         start     <= 1'b0;
         stop      <= 1'b0;
         byte_done <= 1'b0;
         rx_byte   <= 8'h00;
         rx_sr     <= 8'h00;
         tx_sr     <= 8'h00;
         bit_cnt   <= 3'd0;
      end else begin
         sck_sync  <= {sck_sync[SYNC-2:0], sck};
         ssel_sync <= {ssel_sync[SYNC-2:0], ssel};
         mosi_sync <= {mosi_sync[SYNC-2:0], mosi};
         sck_prev  <= sck_s;
         ssel_prev <= ssel_s;
         start     <= ssel_prev & ~ssel_s;
         stop      <= ~ssel_prev & ssel_s;
         byte_done <= 1'b0;
         if (ssel_prev & ~ssel_s) begin
            bit_cnt <= 3'd0;
         end else if (~ssel_s && sck_rise) begin
            rx_sr   <= {rx_sr[6:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               byte_done <= 1'b1;
               rx_byte   <= {rx_sr[6:0], mosi_s};
            end
         end
         // The fall right after a byte boundary keeps the freshly loaded MSB on miso
         if (tx_load) begin
            tx_sr <= tx_byte;
         end else if (~ssel_s && sck_fall && bit_cnt != 3'd0) begin
            tx_sr <= {tx_sr[6:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/spi_frame_slave.sv
// SPI frame slave: snapshot readback, shadowed control writes, atomic commit on a well-formed frame.
// Optional checksum byte enabled by defining SPI_FRAME_CRC_EN.
module spi_frame_slave
   import spi_frame_pkg::*;
#(
   parameter int CH    = 4,
   parameter int PW    = 21,
   parameter int VW    = 12,
   parameter int DOUTW = 14,
   parameter int DINW  = 16,
   parameter int T     = 4,
   parameter int SYNC  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sck,
   input  logic             ssel,
   input  logic             mosi,
   output logic             miso,
   input  logic [CH*PW-1:0] pos,
   input  logic [DINW-1:0]  din,
   output logic [CH*VW-1:0] vel,
   output logic [DOUTW-1:0] dout,
   output logic [T-1:0]     dirtime,
   output logic [T-1:0]     steptime,
   output logic [1:0]       tap,
   output logic             spolarity,
   output logic             wdt_kick,
   output logic             frame_busy,
   output state_t           state_dbg
);

`ifdef SPI_FRAME_CRC_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif
   localparam logic [7:0] L0_B  = 8'(frame_len(CH, 1'b0));
   localparam logic [7:0] L_B   = 8'(frame_len(CH, CRC_EN));
   localparam logic [7:0] TRL_B = 8'(4 * CH);

   state_t           state;
   logic             start, stop, byte_done, tx_load, len_ok, crc_ok;
   logic [2:0]       bit_cnt;
   logic [7:0]       rx_byte, tx_byte, rb_byte, byte_cnt, byte_nxt;
   logic [7:0]       rx_xor, rx_xor_nxt, tx_xor, commit_seq;
   logic [3:0]       len_err_cnt, crc_err_cnt;
   logic [CH*PW-1:0] pos_img;
   logic [DINW-1:0]  din_img;
   logic [CH*16-1:0] vel_sh, vel_sh_nxt;
   logic [15:0]      dout_sh, dout_sh_nxt, din16;
   logic [7:0]       dir_sh, dir_sh_nxt, step_sh, step_sh_nxt;
   logic [23:0]      pos24, pos24_live;

   spi_byte_shifter #(.SYNC(SYNC)) u_shifter (
      .clk(clk), .reset(reset), .sck(sck), .ssel(ssel), .mosi(mosi),
      .tx_load(tx_load), .tx_byte(tx_byte), .miso(miso),
      .start(start), .stop(stop), .byte_done(byte_done),
      .rx_byte(rx_byte), .bit_cnt(bit_cnt)
   );

   assign state_dbg  = state;
   assign pos24_live = 24'(pos[PW-1:0]);
   assign din16      = 16'(din_img);
   assign tx_load    = (state == IDLE && start) || (state == SHIFT && byte_done);
   assign tx_byte    = (state == IDLE) ? pos24_live[7:0] : rb_byte;

   // Next-state view including a byte that completes in this very cycle
   always_comb begin
      byte_nxt    = byte_cnt;
      rx_xor_nxt  = rx_xor;
      vel_sh_nxt  = vel_sh;
      dout_sh_nxt = dout_sh;
      dir_sh_nxt  = dir_sh;
      step_sh_nxt = step_sh;
      if (state == SHIFT && byte_done) begin
         byte_nxt = (byte_cnt == 8'hFF) ? byte_cnt : byte_cnt + 8'd1;
         if (byte_cnt < L_B) rx_xor_nxt = rx_xor ^ rx_byte;
         if (byte_cnt < TRL_B) begin
            if (byte_cnt[1:0] == 2'd0) vel_sh_nxt[int'(byte_cnt[7:2])*16 +: 8] = rx_byte;
            if (byte_cnt[1:0] == 2'd1) vel_sh_nxt[int'(byte_cnt[7:2])*16 + 8 +: 8] = rx_byte;
         end else if (byte_cnt == TRL_B + 8'(TRL_DOUT_LO)) dout_sh_nxt[7:0]  = rx_byte;
         else if (byte_cnt == TRL_B + 8'(TRL_DOUT_HI))     dout_sh_nxt[15:8] = rx_byte;
         else if (byte_cnt == TRL_B + 8'(TRL_DIRTIME))     dir_sh_nxt        = rx_byte;
         else if (byte_cnt == TRL_B + 8'(TRL_STEPTIME))    step_sh_nxt       = rx_byte;
      end
      len_ok = (byte_nxt == L_B) && (bit_cnt == 3'd0);
      crc_ok = !CRC_EN || (rx_xor_nxt == 8'h00);
   end

   // Readback byte for the index about to be loaded into the transmitter
   always_comb begin
      rb_byte = 8'h00;
      pos24   = 24'h0;
      if (byte_nxt < TRL_B) begin
         pos24 = 24'(pos_img[int'(byte_nxt[7:2])*PW +: PW]);
         if (byte_nxt[1:0] != 2'd3) rb_byte = pos24[8*int'(byte_nxt[1:0]) +: 8];
      end else if (byte_nxt == TRL_B + 8'(TRL_DIN_LO)) rb_byte = din16[7:0];
      else if (byte_nxt == TRL_B + 8'(TRL_DIN_HI))     rb_byte = din16[15:8];
      else if (byte_nxt == TRL_B + 8'(TRL_STATUS))
         rb_byte = (8'(len_err_cnt) << STAT_LEN_LSB) | (8'(crc_err_cnt) << STAT_CRC_LSB);
      else if (byte_nxt == TRL_B + 8'(TRL_SEQ))        rb_byte = commit_seq;
      else if (CRC_EN && byte_nxt == L0_B)             rb_byte = tx_xor;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         vel         <= '0;
         dout        <= '0;
         dirtime     <= {T{1'b1}};
         steptime    <= {T{1'b1}};
         tap         <= 2'd0;
         spolarity   <= 1'b0;
         wdt_kick    <= 1'b0;
         frame_busy  <= 1'b0;
         byte_cnt    <= 8'h00;
         rx_xor      <= 8'h00;
         tx_xor      <= 8'h00;
         commit_seq  <= 8'h00;
         len_err_cnt <= 4'h0;
         crc_err_cnt <= 4'h0;
         pos_img     <= '0;
         din_img     <= '0;
         vel_sh      <= '0;
         dout_sh     <= 16'h0;
         dir_sh      <= 8'h00;
         step_sh     <= 8'h00;
      end else begin
         wdt_kick <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= SHIFT;
                  frame_busy <= 1'b1;
                  byte_cnt   <= 8'h00;
                  rx_xor     <= 8'h00;
                  tx_xor     <= pos24_live[7:0];
                  pos_img    <= pos;
                  din_img    <= din;
               end
            end
            SHIFT: begin
               byte_cnt <= byte_nxt;
               rx_xor   <= rx_xor_nxt;
               vel_sh   <= vel_sh_nxt;
               dout_sh  <= dout_sh_nxt;
               dir_sh   <= dir_sh_nxt;
               step_sh  <= step_sh_nxt;
               if (byte_done && byte_nxt < L0_B) tx_xor <= tx_xor ^ rb_byte;
               if (stop) begin
                  state      <= COMMIT;
                  frame_busy <= 1'b0;
                  if (len_ok && crc_ok) begin
                     for (int c = 0; c < CH; c++) vel[c*VW +: VW] <= vel_sh_nxt[c*16 +: VW];
                     dout       <= dout_sh_nxt[DOUTW-1:0];
                     spolarity  <= dir_sh_nxt[7];
                     dirtime    <= dir_sh_nxt[T-1:0];
                     tap        <= step_sh_nxt[7:6];
                     steptime   <= step_sh_nxt[T-1:0];
                     wdt_kick   <= 1'b1;
                     commit_seq <= commit_seq + 8'd1;
                  end else if (!len_ok) begin
                     if (len_err_cnt != 4'hF) len_err_cnt <= len_err_cnt + 4'd1;
                  end else if (CRC_EN && crc_err_cnt != 4'hF) begin
                     crc_err_cnt <= crc_err_cnt + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
